// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter
// Shares one combinational FP divider among NUM_REQ requesters. A round-robin
// arbiter accepts one request and registers its operands onto div_a/div_b. It
// holds them for DIV_LATENCY cycles so the divider path can settle, then
// captures the quotient. The quotient goes back to the owning requester over a
// valid/ready handshake.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot or 0)
//   req_a/req_b         packed operands, requester i on bits [32*i+31:32*i]
//   rsp_valid/rsp_ready per-requester response handshake (valid is one-hot)
//   rsp_result, rsp_dz  registered quotient and divisor-is-zero flag
//   div_a/div_b         registered operands to the divider
//   div_result          divider output, combinational from div_a/div_b
//   busy                high whenever the controller is not idle
//
// state  | meaning
// S_IDLE | waiting for a request, arbiter grant visible on req_ready
// S_BUSY | operands held on the divider, cnt counting down the settle time
// S_RESP | quotient captured, rsp_valid held until the owner takes it
module fp_div_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DIV_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [31:0]            rsp_result,
   output logic                   rsp_dz,
   output logic [31:0]            div_a,
   output logic [31:0]            div_b,
   input  logic [31:0]            div_result,
   output logic                   busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     div_a_q, div_a_d;
   logic [31:0]     div_b_q, div_b_d;
   logic [31:0]     rsp_result_q, rsp_result_d;
   logic            rsp_dz_q, rsp_dz_d;

   logic [31:0]     a_arr [NUM_REQ];
   logic [31:0]     b_arr [NUM_REQ];
   logic            grant_found;
   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   cand;
   logic [PW-1:0]   ptr_next;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         a_arr[i] = req_a[32*i +: 32];
         b_arr[i] = req_b[32*i +: 32];
      end
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign ptr_next = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      div_a_d      = div_a_q;
      div_b_d      = div_b_q;
      rsp_result_d = rsp_result_q;
      rsp_dz_d     = rsp_dz_q;
      case (state_q)
         S_IDLE: begin
            // grant_found implies req_ready[grant_idx] is high, so this is the handshake.
            if (grant_found) begin
               div_a_d  = a_arr[grant_idx];
               div_b_d  = b_arr[grant_idx];
               owner_d  = grant_idx;
               rr_ptr_d = ptr_next;
               cnt_d    = CNT_INIT;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               rsp_result_d = div_result;
               rsp_dz_d     = (div_b_q[30:0] == 31'd0);
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready[owner_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         cnt_q        <= '0;
         div_a_q      <= '0;
         div_b_q      <= '0;
         rsp_result_q <= '0;
         rsp_dz_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         div_a_q      <= div_a_d;
         div_b_q      <= div_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_dz_q     <= rsp_dz_d;
      end
   end

   // req_ready is combinational; gating with rst keeps it low while reset is held.
   assign req_ready  = (!rst && state_q == S_IDLE && grant_found) ? (ONE << grant_idx) : '0;
   assign rsp_valid  = (state_q == S_RESP) ? (ONE << owner_q) : '0;
   assign busy       = (state_q != S_IDLE);
   assign rsp_result = rsp_result_q;
   assign rsp_dz     = rsp_dz_q;
   assign div_a      = div_a_q;
   assign div_b      = div_b_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter. Three instances share the stimulus:
// u_dut (DIV_LATENCY=2) carries most checks, while u_dut_l1 and u_dut_l4 cover the
// latency and reset cases for DIV_LATENCY=1 and 4. Each instance drives a
// table-based divider model that knows the operand pairs used here.
module tb_fp_div_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [127:0]  req_a, req_b;
   logic [3:0]    rsp_ready;

   logic [3:0]    m_req_ready, m_rsp_valid;
   logic [31:0]   m_rsp_result, m_div_a, m_div_b, m_div_result;
   logic          m_rsp_dz, m_busy;
   logic [3:0]    p_req_ready, p_rsp_valid;
   logic [31:0]   p_rsp_result, p_div_a, p_div_b, p_div_result;
   logic          p_rsp_dz, p_busy;
   logic [3:0]    q_req_ready, q_rsp_valid;
   logic [31:0]   q_rsp_result, q_div_a, q_div_b, q_div_result;
   logic          q_rsp_dz, q_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h3F000000}: fdiv = 32'h40000000;
         {32'h40C00000, 32'h40000000}: fdiv = 32'h40400000;
         {32'h40C00000, 32'hC0000000}: fdiv = 32'hC0400000;
         {32'hBF800000, 32'hBF000000}: fdiv = 32'h40000000;
         {32'h40800000, 32'h40000000}: fdiv = 32'h40000000;
         {32'h40000000, 32'h80000000}: fdiv = 32'hFF800000;
         default:                      fdiv = a ^ b;
      endcase
   endfunction

   assign m_div_result = fdiv(m_div_a, m_div_b);
   assign p_div_result = fdiv(p_div_a, p_div_b);
   assign q_div_result = fdiv(q_div_a, q_div_b);

   fp_div_arbiter #(.NUM_REQ(4), .DIV_LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(m_req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(m_rsp_result), .rsp_dz(m_rsp_dz), .div_a(m_div_a), .div_b(m_div_b),
      .div_result(m_div_result), .busy(m_busy));

   fp_div_arbiter #(.NUM_REQ(4), .DIV_LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(p_req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(p_rsp_result), .rsp_dz(p_rsp_dz), .div_a(p_div_a), .div_b(p_div_b),
      .div_result(p_div_result), .busy(p_busy));

   fp_div_arbiter #(.NUM_REQ(4), .DIV_LATENCY(4)) u_dut_l4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(q_req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(q_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(q_rsp_result), .rsp_dz(q_rsp_dz), .div_a(q_div_a), .div_b(q_div_b),
      .div_result(q_div_result), .busy(q_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ab(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   logic [31:0] ea2 [4] = '{32'h40C00000, 32'h40C00000, 32'hBF800000, 32'h40800000};
   logic [31:0] eb2 [4] = '{32'h40000000, 32'hC0000000, 32'hBF000000, 32'h40000000};
   logic [31:0] er2 [4] = '{32'h40400000, 32'hC0400000, 32'h40000000, 32'h40000000};
   int          eg4 [4] = '{1, 2, 1, 2};
   logic [31:0] er4 [4] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40400000};

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
      #3;
      chk("rst_req_ready",  32'(m_req_ready), 32'h0);
      chk("rst_rsp_valid",  32'(m_rsp_valid), 32'h0);
      chk("rst_rsp_result", m_rsp_result,     32'h0);
      chk("rst_rsp_dz",     32'(m_rsp_dz),    32'h0);
      chk("rst_div_a",      m_div_a,          32'h0);
      chk("rst_div_b",      m_div_b,          32'h0);
      chk("rst_busy",       32'(m_busy),      32'h0);
      tick(); tick();
      rst = 1'b0;

      // single operation, 1.0 / 0.5
      set_ab(0, 32'h3F800000, 32'h3F000000);
      req_valid = 4'b0001;
      #1;
      chk("t1_req_ready", 32'(m_req_ready), 32'h1);
      chk("t1_idle_busy", 32'(m_busy), 32'h0);
      tick();
      chk("t1_busy", 32'(m_busy), 32'h1);
      chk("t1_ready_in_busy", 32'(m_req_ready), 32'h0);
      chk("t1_div_a", m_div_a, 32'h3F800000);
      chk("t1_div_b", m_div_b, 32'h3F000000);
      req_valid = '0;
      tick();
      chk("t1_rsp_early", 32'(m_rsp_valid), 32'h0);
      tick();
      chk("t1_rsp_valid", 32'(m_rsp_valid), 32'h1);
      chk("t1_result", m_rsp_result, 32'h40000000);
      chk("t1_dz", 32'(m_rsp_dz), 32'h0);
      rsp_ready = 4'b0001;
      tick();
      chk("t1_back_idle", 32'(m_busy), 32'h0);
      chk("t1_rsp_drop", 32'(m_rsp_valid), 32'h0);
      chk("t1_div_a_kept", m_div_a, 32'h3F800000);

      // four simultaneous requests after reset, grant order 0..3
      rst = 1'b1; #1; rst = 1'b0;
      for (int k = 0; k < 4; k++) set_ab(k, ea2[k], eb2[k]);
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("t2_grant", 32'(m_req_ready), 32'(4'b0001 << k));
         tick();
         req_valid = req_valid & ~(4'b0001 << k);
         chk("t2_div_a", m_div_a, ea2[k]);
         tick(); tick();
         chk("t2_rsp_valid", 32'(m_rsp_valid), 32'(4'b0001 << k));
         chk("t2_result", m_rsp_result, er2[k]);
         tick();
      end
      req_valid = 4'b1001;
      #1;
      chk("t2_ptr_wrap", 32'(m_req_ready), 32'h1);
      req_valid = '0;

      // backpressure on owner 2, non-owner ready bits high
      set_ab(2, 32'h40C00000, 32'h40000000);
      req_valid = 4'b0100;
      rsp_ready = 4'b0000;
      #1;
      chk("t3_grant", 32'(m_req_ready), 32'h4);
      tick();
      req_valid = '0;
      tick(); tick();
      for (int c = 0; c < 5; c++) begin
         req_valid = 4'b0001;
         rsp_ready = 4'b1011;
         #1;
         chk("t3_ready_blocked", 32'(m_req_ready), 32'h0);
         chk("t3_rsp_valid", 32'(m_rsp_valid), 32'h4);
         chk("t3_result", m_rsp_result, 32'h40400000);
         chk("t3_dz", 32'(m_rsp_dz), 32'h0);
         chk("t3_div_a", m_div_a, 32'h40C00000);
         chk("t3_div_b", m_div_b, 32'h40000000);
         tick();
      end
      rsp_ready = 4'b0100;
      tick();
      chk("t3_release_idle", 32'(m_busy), 32'h0);
      chk("t3_release_rsp", 32'(m_rsp_valid), 32'h0);
      chk("t3_next_grant", 32'(m_req_ready), 32'h1);
      req_valid = '0;
      rsp_ready = 4'b1111;

      // fairness between requesters 1 and 2 (rr_ptr is 3 here)
      set_ab(1, 32'h40800000, 32'h40000000);
      set_ab(2, 32'h40C00000, 32'h40000000);
      req_valid = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_grant", 32'(m_req_ready), 32'(4'b0001 << eg4[k]));
         tick(); tick(); tick();
         chk("t4_rsp_valid", 32'(m_rsp_valid), 32'(4'b0001 << eg4[k]));
         chk("t4_result", m_rsp_result, er4[k]);
         tick();
      end
      req_valid = '0;

      // divide by -0
      set_ab(0, 32'h40000000, 32'h80000000);
      req_valid = 4'b0001;
      #1;
      chk("t5_grant", 32'(m_req_ready), 32'h1);
      tick();
      req_valid = '0;
      tick(); tick();
      chk("t5_rsp_valid", 32'(m_rsp_valid), 32'h1);
      chk("t5_result", m_rsp_result, 32'hFF800000);
      chk("t5_dz", 32'(m_rsp_dz), 32'h1);
      tick();
      chk("t5_idle", 32'(m_busy), 32'h0);

      // reset while busy, for latencies 2, 1 and 4
      rst = 1'b1; #1; rst = 1'b0;
      rsp_ready = 4'b0000;
      set_ab(3, 32'h40800000, 32'h40000000);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      chk("t6_busy_l2", 32'(m_busy), 32'h1);
      chk("t6_busy_l1", 32'(p_busy), 32'h1);
      chk("t6_busy_l4", 32'(q_busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("t6_rst_req_ready",  32'(m_req_ready), 32'h0);
      chk("t6_rst_rsp_valid",  32'(m_rsp_valid), 32'h0);
      chk("t6_rst_rsp_result", m_rsp_result,     32'h0);
      chk("t6_rst_rsp_dz",     32'(m_rsp_dz),    32'h0);
      chk("t6_rst_div_a",      m_div_a,          32'h0);
      chk("t6_rst_div_b",      m_div_b,          32'h0);
      chk("t6_rst_busy",       32'(m_busy),      32'h0);
      chk("t6_rst_busy_l1",    32'(p_busy),      32'h0);
      chk("t6_rst_busy_l4",    32'(q_busy),      32'h0);
      tick(); tick();
      chk("t6_no_rsp_l2", 32'(m_rsp_valid), 32'h0);
      chk("t6_no_rsp_l1", 32'(p_rsp_valid), 32'h0);
      chk("t6_no_rsp_l4", 32'(q_rsp_valid), 32'h0);
      rst = 1'b0;
      set_ab(3, 32'h40C00000, 32'hC0000000);
      req_valid = 4'b1000;
      #1;
      chk("t6_grant_l2", 32'(m_req_ready), 32'h8);
      chk("t6_grant_l1", 32'(p_req_ready), 32'h8);
      chk("t6_grant_l4", 32'(q_req_ready), 32'h8);
      tick();
      req_valid = '0;
      for (int n = 1; n <= 4; n++) begin
         tick();
         chk("t6_lat_l2", 32'(m_rsp_valid), (n >= 2) ? 32'h8 : 32'h0);
         chk("t6_lat_l1", 32'(p_rsp_valid), (n >= 1) ? 32'h8 : 32'h0);
         chk("t6_lat_l4", 32'(q_rsp_valid), (n >= 4) ? 32'h8 : 32'h0);
      end
      chk("t6_result_l2", m_rsp_result, 32'hC0400000);
      chk("t6_result_l1", p_rsp_result, 32'hC0400000);
      chk("t6_result_l4", q_rsp_result, 32'hC0400000);
      rsp_ready = 4'b1000;
      tick();
      chk("t6_idle_l2", 32'(m_busy), 32'h0);
      chk("t6_idle_l1", 32'(p_busy), 32'h0);
      chk("t6_idle_l4", 32'(q_busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
